// File: rtl/ghash_ctrl.sv
// ghash_ctrl: sequences GHASH blocks through an external GF(2^128) multiplier.
// Optional E(K,J0) tag masking (port iEkj0) is built when GHASH_TAG_MASK_EN is defined.
module ghash_ctrl #(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic         clk,
  input  logic         iRstn,
  input  logic         iStart,
  input  logic [127:0] iHashkey,
  input  logic [127:0] iBlock,
  input  logic         iBlockValid,
  input  logic         iBlockLast,
  output logic         oBlockReady,
  output logic [127:0] oMulA,
  output logic [127:0] oMulB,
  input  logic [127:0] iMulResult,
  output logic [127:0] oTag,
  output logic         oTagValid,
`ifdef GHASH_TAG_MASK_EN
  input  logic [127:0] iEkj0,
`endif
  output logic         oBusy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_BLK = 2'd1,
    S_MUL      = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  localparam logic [2:0] LAT_C = 3'(MUL_LAT);

  state_e       state_q, state_d;
  logic [127:0] y_q, y_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         last_q, last_d;
  logic [127:0] mul_a_q, mul_a_d;
  logic [127:0] mul_b_q, mul_b_d;
  logic [127:0] tag_q, tag_d;
  logic         tag_valid_q, tag_valid_d;
  logic         ready_q, ready_d;
  logic         busy_q, busy_d;
  logic [127:0] tag_mask_s;

`ifdef GHASH_TAG_MASK_EN
  assign tag_mask_s = iEkj0;
`else
  assign tag_mask_s = 128'h0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!iRstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (iStart) state_d = S_WAIT_BLK;
        else        state_d = S_IDLE;
      end
      S_WAIT_BLK: begin
        if (iBlockValid) state_d = S_MUL;
        else             state_d = S_WAIT_BLK;
      end
      S_MUL: begin
        // The product is sampled on the edge that ends the last latency cycle.
        if (cnt_q == 3'd1) state_d = last_q ? S_DONE : S_WAIT_BLK;
        else               state_d = S_MUL;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next-values
  always_comb begin
    y_d         = y_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    tag_d       = tag_q;
    tag_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          mul_b_d = iHashkey;
          y_d     = 128'h0;
          last_d  = 1'b0;
        end else begin
          mul_b_d = mul_b_q;
        end
      end
      S_WAIT_BLK: begin
        if (iBlockValid) begin
          mul_a_d = y_q ^ iBlock;
          last_d  = iBlockLast;
          cnt_d   = LAT_C;
        end else begin
          mul_a_d = mul_a_q;
        end
      end
      S_MUL: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) y_d = iMulResult;
        else               y_d = y_q;
      end
      S_DONE: begin
        tag_d       = y_q ^ tag_mask_s;
        tag_valid_d = 1'b1;
      end
      default: begin
        tag_valid_d = 1'b0;
      end
    endcase
    ready_d = (state_d == S_WAIT_BLK);
    busy_d  = (state_d != S_IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!iRstn) begin
      y_q         <= 128'h0;
      cnt_q       <= 3'd0;
      last_q      <= 1'b0;
      mul_a_q     <= 128'h0;
      mul_b_q     <= 128'h0;
      tag_q       <= 128'h0;
      tag_valid_q <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      tag_q       <= tag_d;
      tag_valid_q <= tag_valid_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign oBlockReady = ready_q;
  assign oMulA       = mul_a_q;
  assign oMulB       = mul_b_q;
  assign oTag        = tag_q;
  assign oTagValid   = tag_valid_q;
  assign oBusy       = busy_q;

endmodule

// File: doc/ghash_ctrl.md
GHASH_CTRL -- requirements
Module: ghash_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 1: cycles from a change on oMulA/oMulB to a valid iMulResult; legal range 1..7.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 iRstn  input  1  reset, synchronous, active-low.
REQ-004 iStart  input  1  one-cycle pulse that opens a new GHASH computation.
REQ-005 iHashkey  input  128  hash subkey H; sampled only on an accepted iStart.
REQ-006 iBlock  input  128  data block X_i (AAD, ciphertext or length block; pre-padded by host).
REQ-007 iBlockValid  input  1  iBlock is valid this cycle.
REQ-008 iBlockLast  input  1  qualifies iBlock as the final block; sampled with iBlockValid.
REQ-009 oBlockReady  output  1  controller accepts a block this cycle.
REQ-010 oMulA  output  128  multiplier operand (Y xor X_i), registered.
REQ-011 oMulB  output  128  multiplier operand H, registered.
REQ-012 iMulResult  input  128  product returned by the external gfmul instance.
REQ-013 oTag  output  128  final GHASH value (masked per REQ-030).
REQ-014 oTagValid  output  1  one-cycle pulse; oTag is valid this cycle.
REQ-015 oBusy  output  1  high in every state except IDLE.
REQ-016 iEkj0  input  128  E(K,J0) mask; present only when GHASH_TAG_MASK_EN is defined.

Function
REQ-017 The FSM shall have four states, IDLE, WAIT_BLK, MUL and DONE, and no others.
REQ-018 In IDLE with iStart=1, the controller shall latch iHashkey into oMulB, clear accumulator Y to 0, clear the last flag and enter WAIT_BLK.
REQ-019 iStart outside IDLE shall be ignored, with no effect on any state or output.
REQ-020 oBlockReady shall be 1 only in WAIT_BLK.
REQ-021 A block is accepted when iBlockValid=1 and oBlockReady=1 (cycle T); oMulA shall load Y xor iBlock, iBlockLast shall be latched, a latency counter shall load MUL_LAT, and the FSM shall enter MUL.
REQ-022 iBlockValid with oBlockReady=0 shall be ignored; the host shall hold the block until accepted.
REQ-023 oMulA and oMulB shall stay stable from cycle T+1 through cycle T+MUL_LAT inclusive.
REQ-024 Y shall load iMulResult at the rising edge that ends cycle T+MUL_LAT.
REQ-025 On that same edge the FSM shall enter DONE if the latched last flag is 1, otherwise WAIT_BLK; back-to-back blocks are therefore accepted every MUL_LAT+1 cycles.
REQ-026 In DONE, oTag shall load the final Y (masked per REQ-030), oTagValid shall pulse for exactly one cycle, and the FSM shall enter IDLE on the next edge.
REQ-027 oTag shall hold its value until the next DONE; oMulA and oMulB shall hold their values while in IDLE.
REQ-028 All 128-bit operations shall be bitwise XOR only; the controller contains no field arithmetic.

Reset
REQ-029 When iRstn=0 at a rising edge, from any state including mid-MUL, the controller shall force: FSM=IDLE, Y=0, counter=0, last flag=0, oMulA=0, oMulB=0, oTag=0, oTagValid=0, oBlockReady=0, oBusy=0. A multiplier result in flight shall be discarded.

Configuration
REQ-030 With GHASH_TAG_MASK_EN defined, port iEkj0 shall exist and oTag shall equal Y xor iEkj0, with iEkj0 sampled in DONE. Without it, iEkj0 shall be absent and oTag shall equal Y.

Verification
REQ-031 Stub multiplier (iMulResult = oMulA delayed MUL_LAT), MUL_LAT=1, blocks 0x01 then 0x03 (last) -> oTag=0x02, oTagValid high for exactly 1 cycle.
REQ-032 Real gfmul, H=b83b533708bf535d0aa6e52980d53b78, single last block feedfacedeadbeeffeedfacedeadbeef -> oTag equals the golden gfmul(X,H) value.
REQ-033 MUL_LAT=3 stub, iBlockValid held high for 4 blocks -> oBlockReady asserted every 4th cycle, oMulA stable for 3 cycles, final oTag equals the XOR of all 4 blocks.
REQ-034 iStart pulsed while in MUL -> no effect; H and Y unchanged; tag identical to the run without the pulse.
REQ-035 iRstn=0 for one cycle during MUL of the second block -> all outputs 0 next cycle, no oTagValid; a fresh run afterwards produces the correct tag.
REQ-036 GHASH_TAG_MASK_EN defined, iEkj0=ffff...ff, stub run from REQ-031 -> oTag=ffff...fd.
